// File: rtl/tdc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tdc_pkg : shared state type and default sizing for the TDC coarse sequencer.
// Rev 1.0
// ----------------------------------------------------------------------------
package tdc_pkg;

  localparam int c_DIG_DEFAULT     = 10;
  localparam int c_TIMEOUT_DEFAULT = 1000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_STORE = 3'd3,
    S_LATCH = 3'd4,
    S_VALID = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/tdc_timeout_cnt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tdc_timeout_cnt : mirror of the coarse counter, flags the last count before
// a forced stop. Rev 1.0
// ----------------------------------------------------------------------------
module tdc_timeout_cnt
  import tdc_pkg::*;
#(
  parameter int C_DIG = c_DIG_DEFAULT,
  parameter int LIMIT = c_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_ce,
  output logic o_at_limit
);

  localparam logic [C_DIG-1:0] c_LAST = C_DIG'(LIMIT - 1);

  logic [C_DIG-1:0] r_count;

  // Cleared together with the real counter so both always hold the same value.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_ce) begin
      r_count <= r_count + C_DIG'(1);
    end
  end

  assign o_at_limit = i_ce && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/tdc_coarse_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tdc_coarse_ctrl : arms, runs, stops and reads out one coarse TDC measurement.
// Rev 1.0
// ----------------------------------------------------------------------------
module tdc_coarse_ctrl
  import tdc_pkg::*;
#(
  parameter int C_DIG   = c_DIG_DEFAULT,
  parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             iRst,
  input  logic             iArm,
  input  logic             iStart,
  input  logic             iStop,
  input  logic             iAbort,
  input  logic [C_DIG-1:0] iCoarse,
  input  logic             iReady,
  output logic             oCntRst,
  output logic             oCntCE,
  output logic             oCntStore,
  output logic             oValid,
  output logic [C_DIG-1:0] oData,
  output logic             oTimeout,
  output logic             oBusy
);

  state_e r_state;
  state_e w_next;
  logic   r_to_flag;
  logic   w_at_limit;

  tdc_timeout_cnt #(
    .C_DIG (C_DIG),
    .LIMIT (TIMEOUT)
  ) u_mirror (
    .clk        (clk),
    .rst        (iRst),
    .i_clr      (oCntRst),
    .i_ce       (oCntCE),
    .o_at_limit (w_at_limit)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (iArm) w_next = S_ARMED;
      end
      S_ARMED: begin
        if (iAbort)                w_next = S_IDLE;
        else if (iStart && iStop)  w_next = S_STORE;
        else if (iStart)           w_next = S_RUN;
      end
      S_RUN: begin
        if (iAbort)                    w_next = S_IDLE;
        else if (iStop || w_at_limit)  w_next = S_STORE;
      end
      S_STORE: begin
        w_next = iAbort ? S_IDLE : S_LATCH;
      end
      S_LATCH: begin
        w_next = iAbort ? S_IDLE : S_VALID;
      end
      S_VALID: begin
        if (iReady) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Counter controls are decoded from the next state so they change on the
  // same edge as the state; reset is only ever asserted in IDLE/ARMED, which
  // keeps it disjoint from both enable and store.
  always_ff @(posedge clk) begin
    if (iRst) begin
      r_state   <= S_IDLE;
      r_to_flag <= 1'b0;
      oCntRst   <= 1'b1;
      oCntCE    <= 1'b0;
      oCntStore <= 1'b0;
      oValid    <= 1'b0;
      oData     <= '0;
      oTimeout  <= 1'b0;
      oBusy     <= 1'b0;
    end else begin
      r_state   <= w_next;
      oCntRst   <= (w_next == S_IDLE) || (w_next == S_ARMED);
      oCntCE    <= (w_next == S_RUN);
      oCntStore <= (w_next == S_STORE);
      oValid    <= (w_next == S_VALID);
      oBusy     <= (w_next != S_IDLE);

      if ((r_state == S_RUN) && (w_next == S_STORE)) begin
        r_to_flag <= w_at_limit && !iStop;
      end else if ((r_state == S_ARMED) && (w_next == S_STORE)) begin
        r_to_flag <= 1'b0;
      end

      // The counter's stored register settled at the end of STORE.
      if ((r_state == S_LATCH) && (w_next == S_VALID)) begin
        oData    <= iCoarse;
        oTimeout <= r_to_flag;
      end
    end
  end

endmodule
`default_nettype wire
